// File: rtl/conv_operand_feeder.sv
`default_nettype none
// ============================================================================
// Module   : conv_operand_feeder
// Brief    : Walks x, y, ch_in, ch_out, k_v; fetches one zero-padded activation
//            row and one weight row per MAC step and offers them on a/b.
// Revision : 1.0
// ============================================================================
module conv_operand_feeder #(
    parameter int LOG2_OF_MEM_HEIGHT = 20,
    parameter int DATA_WIDTH         = 16,
    parameter int FEATURE_MAP_WIDTH  = 1024,
    parameter int FEATURE_MAP_HEIGHT = 1024,
    parameter int INPUT_NB_CHANNELS  = 64,
    parameter int OUTPUT_NB_CHANNELS = 64,
    parameter int KERNEL_SIZE        = 3
) (
    input  logic                               clk,
    input  logic                               arst_n_in,
    input  logic                               start,
    output logic                               running,
    output logic                               done,
    output logic                               act_re,
    output logic [LOG2_OF_MEM_HEIGHT-1:0]      act_addr,
    input  logic [DATA_WIDTH-1:0]              act_rdata,
    output logic                               wgt_re,
    output logic [LOG2_OF_MEM_HEIGHT-1:0]      wgt_addr,
    input  logic [KERNEL_SIZE*DATA_WIDTH-1:0]  wgt_rdata,
    output logic [KERNEL_SIZE*DATA_WIDTH-1:0]  a_data,
    output logic                               a_valid,
    input  logic                               a_ready,
    output logic [KERNEL_SIZE*DATA_WIDTH-1:0]  b_data,
    output logic                               b_valid,
    input  logic                               b_ready
);

    localparam int          c_ROW  = KERNEL_SIZE * DATA_WIDTH;
    localparam logic [31:0] c_W    = 32'(FEATURE_MAP_WIDTH);
    localparam logic [31:0] c_H    = 32'(FEATURE_MAP_HEIGHT);
    localparam logic [31:0] c_CIN  = 32'(INPUT_NB_CHANNELS);
    localparam logic [31:0] c_COUT = 32'(OUTPUT_NB_CHANNELS);
    localparam logic [31:0] c_K    = 32'(KERNEL_SIZE);
    localparam logic [31:0] c_PAD  = 32'(KERNEL_SIZE / 2);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_FETCH   = 2'd1,
        S_WAIT    = 2'd2,
        S_PRESENT = 2'd3
    } state_t;

    state_t                          r_state;
    logic [31:0]                     r_x, r_y, r_ci, r_co, r_kv, r_j;
    logic                            r_running, r_done, r_valid;
    logic                            r_act_re, r_wgt_re;
    logic [LOG2_OF_MEM_HEIGHT-1:0]   r_act_addr, r_wgt_addr;
    logic [c_ROW-1:0]                r_a, r_b;
    logic                            r_cap, r_cap_pad, r_wcap;
    logic [31:0]                     r_cap_idx;

    logic                            w_consume, w_last, w_go_fetch, w_inb;
    logic                            w_kv_wrap, w_co_wrap, w_ci_wrap, w_y_wrap, w_x_wrap;
    logic [31:0]                     w_ax, w_ay, w_aci, w_aco, w_akv;
    logic [31:0]                     w_sy, w_sci, w_sco, w_skv, w_sx, w_sj;
    logic [31:0]                     w_xx, w_yy;
    logic [LOG2_OF_MEM_HEIGHT-1:0]   w_act_addr, w_wgt_addr;

    // Next-tuple arithmetic and the fetch slot that will be issued next cycle,
    // so the SRAM request outputs can be registered without adding latency.
    always_comb begin
        w_consume = r_valid && a_ready && b_ready;
        w_kv_wrap = (r_kv == c_K - 32'd1);
        w_co_wrap = (r_co == c_COUT - 32'd1);
        w_ci_wrap = (r_ci == c_CIN - 32'd1);
        w_y_wrap  = (r_y == c_H - 32'd1);
        w_x_wrap  = (r_x == c_W - 32'd1);
        w_last    = w_kv_wrap && w_co_wrap && w_ci_wrap && w_y_wrap && w_x_wrap;

        w_akv = w_kv_wrap ? 32'd0 : r_kv + 32'd1;
        w_aco = !w_kv_wrap ? r_co : (w_co_wrap ? 32'd0 : r_co + 32'd1);
        w_aci = !(w_kv_wrap && w_co_wrap) ? r_ci : (w_ci_wrap ? 32'd0 : r_ci + 32'd1);
        w_ay  = !(w_kv_wrap && w_co_wrap && w_ci_wrap) ? r_y : (w_y_wrap ? 32'd0 : r_y + 32'd1);
        w_ax  = !(w_kv_wrap && w_co_wrap && w_ci_wrap && w_y_wrap) ? r_x
              : (w_x_wrap ? 32'd0 : r_x + 32'd1);

        w_sx  = r_x;
        w_sy  = r_y;
        w_sci = r_ci;
        w_sco = r_co;
        w_skv = r_kv;
        w_sj  = r_j + 32'd1;
        if (r_state == S_PRESENT) begin
            w_sx  = w_ax;
            w_sy  = w_ay;
            w_sci = w_aci;
            w_sco = w_aco;
            w_skv = w_akv;
            w_sj  = 32'd0;
        end else if (r_state == S_IDLE) begin
            w_sj  = 32'd0;
        end

        w_go_fetch = ((r_state == S_IDLE) && start)
                  || ((r_state == S_FETCH) && (r_j != c_K - 32'd1))
                  || ((r_state == S_PRESENT) && w_consume && !w_last);

        // Negative coordinates wrap to large unsigned values; bit 31 flags them.
        w_xx  = w_sx + w_sj - c_PAD;
        w_yy  = w_sy + w_skv - c_PAD;
        w_inb = !w_xx[31] && (w_xx < c_W) && !w_yy[31] && (w_yy < c_H);

        w_act_addr = LOG2_OF_MEM_HEIGHT'(w_sci * c_W * c_H + w_yy * c_W + w_xx);
        w_wgt_addr = LOG2_OF_MEM_HEIGHT'((w_sco * c_CIN + w_sci) * c_K + w_skv);
    end

    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            r_state    <= S_IDLE;
            r_x        <= '0;
            r_y        <= '0;
            r_ci       <= '0;
            r_co       <= '0;
            r_kv       <= '0;
            r_j        <= '0;
            r_running  <= 1'b0;
            r_done     <= 1'b0;
            r_valid    <= 1'b0;
            r_act_re   <= 1'b0;
            r_wgt_re   <= 1'b0;
            r_act_addr <= '0;
            r_wgt_addr <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_cap      <= 1'b0;
            r_cap_pad  <= 1'b0;
            r_cap_idx  <= '0;
            r_wcap     <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_act_re  <= 1'b0;
            r_wgt_re  <= 1'b0;
            r_cap     <= (r_state == S_FETCH);
            r_cap_pad <= !r_act_re;
            r_cap_idx <= r_j;
            r_wcap    <= r_wgt_re;

            // Read data arrives one cycle after the request; padded slots load 0.
            for (int j = 0; j < KERNEL_SIZE; j++) begin
                if (r_cap && (r_cap_idx == 32'(j)))
                    r_a[j*DATA_WIDTH +: DATA_WIDTH] <= r_cap_pad ? '0 : act_rdata;
            end
            if (r_wcap)
                r_b <= wgt_rdata;

            if (w_go_fetch) begin
                r_act_re <= w_inb;
                if (w_inb)
                    r_act_addr <= w_act_addr;
                r_wgt_re <= (w_sj == 32'd0);
                if (w_sj == 32'd0)
                    r_wgt_addr <= w_wgt_addr;
            end

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state   <= S_FETCH;
                        r_j       <= '0;
                        r_running <= 1'b1;
                    end
                end
                S_FETCH: begin
                    if (r_j == c_K - 32'd1)
                        r_state <= S_WAIT;
                    else
                        r_j <= r_j + 32'd1;
                end
                S_WAIT: begin
                    r_state <= S_PRESENT;
                    r_valid <= 1'b1;
                end
                S_PRESENT: begin
                    if (w_consume) begin
                        r_valid <= 1'b0;
                        r_x     <= w_ax;
                        r_y     <= w_ay;
                        r_ci    <= w_aci;
                        r_co    <= w_aco;
                        r_kv    <= w_akv;
                        r_j     <= '0;
                        if (w_last) begin
                            r_state   <= S_IDLE;
                            r_running <= 1'b0;
                            r_done    <= 1'b1;
                        end else begin
                            r_state <= S_FETCH;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign running  = r_running;
    assign done     = r_done;
    assign act_re   = r_act_re;
    assign act_addr = r_act_addr;
    assign wgt_re   = r_wgt_re;
    assign wgt_addr = r_wgt_addr;
    assign a_data   = r_a;
    assign b_data   = r_b;
    assign a_valid  = r_valid;
    assign b_valid  = r_valid;

endmodule
`default_nettype wire
